// File: rtl/time_score_display_pkg.sv
// Shared constants for the time/score seven-segment display: segment patterns,
// converter FSM state encodings and the score saturation limit.
package time_score_display_pkg;

   // Converter FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int         BIN_W       = 7;
   localparam logic [2:0] LAST_STEP   = 3'd6;
   localparam logic [6:0] SCORE_MAX   = 7'd99;

   // Active-low {dp,g,f,e,d,c,b,a}; dp bit is always 1 (off)
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
      logic [7:0] pat;
      pat = SEG_BLANK;
      case (digit)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

   // Double-dabble correction applied to a BCD nibble before each shift
   function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
      return (nib >= 4'd5) ? (nib + 4'd3) : nib;
   endfunction

endpackage

// File: rtl/time_score_display_bcd_converter.sv
// Sequential double-dabble converter: 7-bit binary to two BCD nibbles, one bit per
// cycle. The FSM state is exported on state_dbg.
module bcd_converter
   import time_score_display_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             done,
   output logic [3:0]       tens,
   output logic [3:0]       ones,
   output logic [1:0]       state_dbg
);

   // Handshake: start is sampled only in IDLE; bin is captured in LOAD; done is a
   // one-cycle pulse in DONE and tens/ones are valid during that cycle. No backpressure.
   logic [1:0]  state;
   logic [2:0]  step_cnt;
   logic [14:0] scratch;
   logic [14:0] adjusted;

   assign adjusted = {dabble_adjust(scratch[14:11]), dabble_adjust(scratch[10:7]), scratch[6:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         step_cnt <= 3'd0;
         scratch  <= 15'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) state <= ST_LOAD;
            end
            ST_LOAD: begin
               scratch  <= {8'd0, bin};
               step_cnt <= 3'd0;
               state    <= ST_SHIFT;
            end
            ST_SHIFT: begin
               scratch  <= adjusted << 1;
               step_cnt <= step_cnt + 3'd1;
               if (step_cnt == LAST_STEP) state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign done      = (state == ST_DONE);
   assign tens      = scratch[14:11];
   assign ones      = scratch[10:7];
   assign state_dbg = state;

endmodule

// File: rtl/time_score_display.sv
// Four-digit multiplexed seven-segment display of time remaining and score.
// Optional blink-on-game-end behaviour is enabled by defining BLINK_ON_END_EN.
module time_score_display
   import time_score_display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] time_remaining,
   input  logic [6:0] score,
   input  logic       game_end,
   output logic [7:0] seg,
   output logic [3:0] an
);

   localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   logic [6:0] score_sat;
   logic [6:0] time_ext;
   logic       conv_start;
   logic       time_done;
   logic       score_done;
   logic [3:0] time_tens_bcd;
   logic [3:0] time_ones_bcd;
   logic [3:0] score_tens_bcd;
   logic [3:0] score_ones_bcd;
   logic [1:0] time_state;
   logic [1:0] score_state;

   assign score_sat  = (score > SCORE_MAX) ? SCORE_MAX : score;
   assign time_ext   = {1'b0, time_remaining};
   // Both converters run in lockstep; a new pass starts as soon as both are idle
   assign conv_start = (time_state == ST_IDLE) && (score_state == ST_IDLE);

   bcd_converter u_time_conv (
      .clk       (clk),
      .rst       (rst),
      .start     (conv_start),
      .bin       (time_ext),
      .done      (time_done),
      .tens      (time_tens_bcd),
      .ones      (time_ones_bcd),
      .state_dbg (time_state)
   );

   bcd_converter u_score_conv (
      .clk       (clk),
      .rst       (rst),
      .start     (conv_start),
      .bin       (score_sat),
      .done      (score_done),
      .tens      (score_tens_bcd),
      .ones      (score_ones_bcd),
      .state_dbg (score_state)
   );

   logic [3:0] disp_time_tens;
   logic [3:0] disp_time_ones;
   logic [3:0] disp_score_tens;
   logic [3:0] disp_score_ones;

   // All four digits are replaced together so the display never shows a mixed value
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_time_tens  <= 4'd0;
         disp_time_ones  <= 4'd0;
         disp_score_tens <= 4'd0;
         disp_score_ones <= 4'd0;
      end else if (time_done && score_done) begin
         disp_time_tens  <= time_tens_bcd;
         disp_time_ones  <= time_ones_bcd;
         disp_score_tens <= score_tens_bcd;
         disp_score_ones <= score_ones_bcd;
      end
   end

   logic [RW-1:0] refresh_cnt;
   logic          refresh_tc;
   logic [1:0]    idx;
   logic          scan_on;

   assign refresh_tc = (refresh_cnt == RW'(REFRESH_DIV - 1));

   // The first terminal count only enables scanning, so digit 0 is shown first
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         idx         <= 2'd0;
         scan_on     <= 1'b0;
      end else if (refresh_tc) begin
         refresh_cnt <= '0;
         if (scan_on) idx <= idx + 2'd1;
         else         scan_on <= 1'b1;
      end else begin
         refresh_cnt <= refresh_cnt + RW'(1);
      end
   end

   logic [3:0] cur_digit;

   always_comb begin
      cur_digit = 4'd0;
      case (idx)
         2'd0:    cur_digit = disp_score_ones;
         2'd1:    cur_digit = disp_score_tens;
         2'd2:    cur_digit = disp_time_ones;
         2'd3:    cur_digit = disp_time_tens;
         default: cur_digit = 4'd0;
      endcase
   end

   logic [3:0] an_q;
   logic [7:0] seg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         an_q  <= 4'b1111;
         seg_q <= SEG_BLANK;
      end else if (scan_on) begin
         an_q  <= ~(4'b0001 << idx);
         seg_q <= seg_pattern(cur_digit);
      end else begin
         an_q  <= 4'b1111;
         seg_q <= SEG_BLANK;
      end
   end

   assign seg = seg_q;

`ifdef BLINK_ON_END_EN
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   always_ff @(posedge clk) begin
      if (rst || !game_end) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   // Blanking only masks the anodes; scan and conversion keep running underneath
   assign an = an_q | {4{blink_phase}};
`else
   localparam int unused_blink_div = BLINK_DIV;
   logic unused_game_end;
   assign unused_game_end = game_end;
   assign an = an_q;
`endif

endmodule

// File: tb/tb_time_score_display.sv
// Bench for time_score_display: directed vectors, expected digit slots queued by
// the stimulus and consumed by an independent slot monitor.
module tb_time_score_display;

   localparam int REFRESH_DIV = 4;
   localparam int BLINK_DIV   = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] time_remaining = 6'd0;
   logic [6:0] score = 7'd0;
   logic       game_end = 1'b0;
   logic [7:0] seg;
   logic [3:0] an;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [11:0] exp_q[$];

   time_score_display #(
      .REFRESH_DIV (REFRESH_DIV),
      .BLINK_DIV   (BLINK_DIV)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .time_remaining (time_remaining),
      .score          (score),
      .game_end       (game_end),
      .seg            (seg),
      .an             (an)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [3:0] prev_an = 4'hF;
   int         run_len = 0;
   bit         collecting = 1'b0;

   always @(negedge clk) begin
      logic [11:0] e;
      if (rst) begin
         collecting = 1'b0;
         prev_an    = 4'hF;
         run_len    = 0;
      end else if (an != prev_an && an != 4'hF) begin
         if (collecting) check("slot_len", run_len, REFRESH_DIV);
         if (exp_q.size() > 0 && (collecting || an == 4'b1110)) begin
            e = exp_q.pop_front();
            check("slot_an", {28'd0, an}, {28'd0, e[11:8]});
            check("slot_seg", {24'd0, seg}, {24'd0, e[7:0]});
            collecting = 1'b1;
         end else begin
            collecting = 1'b0;
         end
         run_len = 1;
         prev_an = an;
      end else begin
         run_len++;
         prev_an = an;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic expect_display(input logic [5:0] t, input logic [6:0] s,
                                 input logic [7:0] s0, input logic [7:0] s1,
                                 input logic [7:0] s2, input logic [7:0] s3);
      int waited;
      time_remaining = t;
      score          = s;
      repeat (25) @(negedge clk);
      exp_q.push_back({4'b1110, s0});
      exp_q.push_back({4'b1101, s1});
      exp_q.push_back({4'b1011, s2});
      exp_q.push_back({4'b0111, s3});
      waited = 0;
      while ((exp_q.size() > 0 || collecting) && waited < 80) begin
         @(negedge clk);
         waited++;
      end
      if (exp_q.size() > 0 || collecting) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: actual=%0d pending required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_phase(input int ph);
      for (int i = 0; i < 20 && (cyc % 10) != ph; i++) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int  n;
      bit  seen_new;
      int  blanks;

      // Reset held 3 cycles: outputs dark throughout
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_an", {28'd0, an}, 32'hF);
         check("reset_seg", {24'd0, seg}, 32'hFF);
      end
      time_remaining = 6'd40;
      score          = 7'd7;
      rst            = 1'b0;

      // First digit appears REFRESH_DIV+1 cycles after release, showing cleared regs
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i < 5) check("pre_scan_an", {28'd0, an}, 32'hF);
      end
      check("first_digit_an", {28'd0, an}, 32'hE);
      check("first_digit_seg", {24'd0, seg}, 32'hC0);

      // Directed display vectors
      expect_display(6'd40, 7'd7,   8'hF8, 8'hC0, 8'hC0, 8'h99);
      expect_display(6'd63, 7'd120, 8'h90, 8'h90, 8'hB0, 8'h82);
      expect_display(6'd5,  7'd0,   8'hC0, 8'hC0, 8'h92, 8'hC0);
      expect_display(6'd0,  7'd99,  8'h90, 8'h90, 8'hC0, 8'hC0);
      expect_display(6'd12, 7'd100, 8'h90, 8'h90, 8'hA4, 8'hF9);
      expect_display(6'd37, 7'd58,  8'h80, 8'h92, 8'hF8, 8'hB0);

      // Score changes 7 -> 12 while the converters are shifting
      expect_display(6'd40, 7'd7,   8'hF8, 8'hC0, 8'hC0, 8'h99);
      wait_phase(3);
      score    = 7'd12;
      seen_new = 1'b0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (j <= 12) begin
            if (an == 4'b1110) check("hold_old_ones", {24'd0, seg}, 32'hF8);
            if (an == 4'b1101) check("hold_old_tens", {24'd0, seg}, 32'hC0);
         end else begin
            if ((an == 4'b1110 && seg == 8'hA4) || (an == 4'b1101 && seg == 8'hF9)) seen_new = 1'b1;
            if (seen_new && an == 4'b1110) check("no_mixed_ones", {24'd0, seg}, 32'hA4);
            if (seen_new && an == 4'b1101) check("no_mixed_tens", {24'd0, seg}, 32'hF9);
         end
      end
      check("new_value_seen", {31'd0, seen_new}, 32'd1);

      // Reset mid-SHIFT: dark next cycle, then cleared display until first DONE
      wait_phase(5);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_an", {28'd0, an}, 32'hF);
      check("midrst_seg", {24'd0, seg}, 32'hFF);
      rst = 1'b0;
      n = 0;
      while (an != 4'b1110 && n < 12) begin
         @(negedge clk);
         n++;
      end
      check("post_rst_latency", n, 5);
      check("post_rst_ones", {24'd0, seg}, 32'hC0);
      n = 0;
      while (an != 4'b1101 && n < 12) begin
         @(negedge clk);
         n++;
      end
      check("post_rst_tens", {24'd0, seg}, 32'hC0);
      expect_display(6'd40, 7'd12, 8'hA4, 8'hF9, 8'hC0, 8'h99);

      // game_end behaviour
      game_end = 1'b1;
      blanks   = 0;
      for (int j = 0; j < 32; j++) begin
         @(negedge clk);
         if (an == 4'hF) blanks++;
      end
`ifdef BLINK_ON_END_EN
      check("blink_dark_cycles", blanks, 16);
      game_end = 1'b0;
      @(negedge clk);
      check("blink_resume", {31'd0, (an == 4'hF)}, 32'd0);
`else
      check("steady_on_end", blanks, 0);
      game_end = 1'b0;
`endif
      expect_display(6'd1, 7'd45, 8'h92, 8'h99, 8'hF9, 8'hC0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
